reg_bank_dump: RTL and testbench
================================

# reg_bank_dump

Parametrised general-purpose register bank for the datapath: DEPTH registers of WIDTH bits, one synchronous write port, two combinational read ports, optional hard-wired-zero register 0, and a debug dump engine. The dump engine streams every register out, in address order, over a valid/ready handshake. It sits between the bus/ALU write-back path and the operand read muxes, and replaces individually instantiated 32-bit enable registers.

## Interface
- WIDTH, 32, register width in bits
- DEPTH, 16, number of registers; power of two, at least 2
- ADDR_W, 4, address width; must equal log2(DEPTH)
- R0_ZERO, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary

- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  reset; synchronous, active-low
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  WIDTH  read port A data; combinational
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  WIDTH  read port B data; combinational
- dump_start  in  1  request a full dump
- dump_busy  out  1  dump in progress (SEND or DONE)
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts the beat
- dump_addr  out  ADDR_W  register index of the current beat
- dump_data  out  WIDTH  register contents of the current beat
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset (clr=0 at an edge) clears all registers, state, dump_addr and dump_data to 0, and forces dump_busy, dump_valid and dump_done to 0. Reset overrides any write or dump activity in the same cycle.
- Write: on an edge with clr=1 and wr_en=1, wr_data is stored at wr_addr. If R0_ZERO=1, writes to address 0 are discarded.
- Read: rd_data_x reflects the stored contents of rd_addr_x, giving 0 for address 0 when R0_ZERO=1. There is no write-to-read bypass: a write is visible only after its edge. Both ports may read the same address.
- Dump FSM:
  - IDLE: if dump_start=1, capture dump_data=reg[0], set dump_addr=0, and go to SEND.
  - SEND: dump_valid=1. On each edge with dump_ready=1, the beat is accepted:
    - If dump_addr < DEPTH-1: increment dump_addr and capture dump_data from the new address.
    - If dump_addr = DEPTH-1: go to DONE.
    - With dump_ready=0, dump_addr and dump_data hold and stay stable.
  - DONE: dump_done=1 and dump_valid=0 for exactly one cycle, then go to IDLE. dump_addr returns to 0.
- dump_start is ignored outside IDLE.
- dump_data is captured from the register contents before the capturing edge. A write to that address on the same edge is not reflected. A later write to an already-captured address does not alter the held beat.
- Writes and reads stay fully functional during a dump.
- Reset mid-dump aborts the dump immediately: no dump_done pulse, and state returns to IDLE.

## Timing
- Write latency: 1 edge. Read latency: 0 cycles (combinational).
- Dump start: dump_start is sampled at edge k; dump_valid=1 from edge k until acceptance.
- With dump_ready held at 1, one beat is accepted per cycle. A DEPTH-beat dump then occupies DEPTH SEND cycles plus 1 DONE cycle, and dump_busy stays high for DEPTH+1 cycles.
- Back-to-back dumps: dump_start asserted in the DONE cycle is ignored. It is accepted in the first IDLE cycle, giving at least 1 idle cycle between dumps.
- The address counter never wraps during a dump: the beat at DEPTH-1 is the last one.
- dump_done is registered and is never asserted in the same cycle as dump_valid.

## Test plan
- Reset: write 0xDEADBEEF to R5, then hold clr=0 for one edge -> rd_data_a for R5 = 0; dump_busy, dump_valid and dump_done = 0.
- Write/read (R0_ZERO=1):
  - Write 32'd15 to R1 and 32'd10 to R2, then read A=R1, B=R2 -> 15 and 10.
  - Write 32'd7 to R0 -> reads 0.
  - With wr_en=1 writing 32'd99 to R1 while reading R1 in the same cycle -> read shows 15 before the edge and 99 after it.
- Full dump, ready=1:
  - Preload Rn = n+100 and pulse dump_start -> 16 consecutive beats with dump_addr 0..15 and dump_data 0,101..115.
  - Then dump_done pulses once, and dump_busy is high for exactly 17 cycles.
- Backpressure and concurrent write:
  - During a dump, hold dump_ready=0 for 3 cycles at beat 4 -> dump_addr=4 and dump_data=104 stay stable.
  - Write 0x55 to R4 while it is held -> the beat still carries 104.
  - Write 0x66 to R9 before its beat -> beat 9 carries 0x66.
- Start ignored and abort:
  - Pulse dump_start at beat 6 -> the sequence is unaffected.
  - Assert clr=0 at beat 10 -> next cycle is IDLE, with no dump_done pulse.
  - A new dump_start then restarts the dump from address 0.
- Parameter sweep: WIDTH=8, DEPTH=4, R0_ZERO=0.
  - Write 8'hFF to R0 -> reads 8'hFF.
  - Dump -> 4 beats, addresses 0..3, then dump_done.

Source files
------------

// File: rtl/reg_bank_dump.sv
// reg_bank_dump: register bank with two combinational read ports and a valid/ready dump engine
module reg_bank_dump #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter bit R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] regs [DEPTH];
    logic last, accept, start;
    assign last   = dump_addr == ADDR_W'(DEPTH - 1);
    assign accept = state == SEND && dump_ready;
    assign start  = state == IDLE && dump_start;
    assign rd_data_a = (R0_ZERO && rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (R0_ZERO && rd_addr_b == '0) ? '0 : regs[rd_addr_b];
    assign dump_busy  = state != IDLE;
    assign dump_valid = state == SEND;
    assign dump_done  = state == DONE;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (dump_start ? SEND : IDLE)
                 : state == SEND ? ((dump_ready && last) ? DONE : SEND)
                 : IDLE;
    end
    always_ff @(posedge clk)
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    always_ff @(posedge clk)
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en && !(R0_ZERO && wr_addr == '0)) begin
            regs[wr_addr] <= wr_data;
        end
    // Beats are captured from pre-edge contents so a held beat never changes under a write
    always_ff @(posedge clk)
        if (!clr) begin
            dump_addr <= '0;
            dump_data <= '0;
        end else if (start) begin
            dump_addr <= '0;
            dump_data <= regs[0];
        end else if (accept) begin
            dump_addr <= last ? '0 : dump_addr + 1'b1;
            if (!last) dump_data <= regs[dump_addr + 1'b1];
        end
endmodule

// File: tb/tb_reg_bank_dump.sv
// tb_reg_bank_dump: directed scoreboard bench for the default bank and a small R0-ordinary variant
module tb_reg_bank_dump;
    logic clk = 0, clr = 0;
    logic wr_en = 0, dump_start = 0, dump_ready = 0;
    logic [3:0] wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
    logic [31:0] wr_data = 0;
    logic [31:0] rd_data_a, rd_data_b, dump_data;
    logic [3:0] dump_addr;
    logic dump_busy, dump_valid, dump_done;
    logic s_wr_en = 0, s_start = 0, s_ready = 0;
    logic [1:0] s_wr_addr = 0, s_rd_a = 0, s_rd_b = 0, s_addr;
    logic [7:0] s_wr_data = 0, s_data_a, s_data_b, s_data;
    logic s_busy, s_valid, s_done;
    int checks = 0, errors = 0, done_cnt = 0, s_done_cnt = 0, busy_cnt;
    logic [35:0] q [$];
    logic [9:0] sq [$];

    always #5 clk = ~clk;

    reg_bank_dump dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    reg_bank_dump #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .R0_ZERO(0)) sdut (
        .clk(clk), .clr(clr), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_addr_a(s_rd_a), .rd_data_a(s_data_a), .rd_addr_b(s_rd_b), .rd_data_b(s_data_b),
        .dump_start(s_start), .dump_busy(s_busy), .dump_valid(s_valid),
        .dump_ready(s_ready), .dump_addr(s_addr), .dump_data(s_data), .dump_done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic s_wr(input logic [1:0] a, input logic [7:0] d);
        s_wr_en = 1; s_wr_addr = a; s_wr_data = d;
        step();
        s_wr_en = 0;
    endtask

    task automatic wait_addr(input logic [3:0] a);
        for (int i = 0; i < 60 && dump_addr != a; i++) step();
        chk("reach_beat", 32'(dump_addr), 32'(a));
    endtask

    always @(negedge clk) begin
        if (dump_done) begin
            done_cnt++;
            chk("done_with_valid", 32'(dump_valid), 32'd0);
        end
        if (dump_valid && dump_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL extra_beat observed addr %0h expected no beat", dump_addr);
            end
            if (q.size() > 0) begin
                logic [35:0] e;
                e = q.pop_front();
                chk("beat_addr", 32'(dump_addr), 32'(e[35:32]));
                chk("beat_data", dump_data, e[31:0]);
            end
        end
        if (s_done) s_done_cnt++;
        if (s_valid && s_ready) begin
            checks++;
            assert (sq.size() > 0) else begin
                errors++;
                $error("FAIL s_extra_beat observed addr %0h expected no beat", s_addr);
            end
            if (sq.size() > 0) begin
                logic [9:0] e;
                e = sq.pop_front();
                chk("s_beat_addr", 32'(s_addr), 32'(e[9:8]));
                chk("s_beat_data", 32'(s_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        step(); step();
        clr = 1;
        chk("reset_busy", 32'(dump_busy), 0);
        // reset clears stored data
        wr(5, 32'hDEADBEEF);
        rd_addr_a = 5; #1;
        chk("pre_reset_r5", rd_data_a, 32'hDEADBEEF);
        clr = 0; step(); clr = 1;
        chk("reset_r5", rd_data_a, 0);
        chk("reset_valid", 32'(dump_valid), 0);
        chk("reset_done", 32'(dump_done), 0);
        // write / read
        wr(1, 15); wr(2, 10);
        rd_addr_a = 1; rd_addr_b = 2; #1;
        chk("rd_a_r1", rd_data_a, 15);
        chk("rd_b_r2", rd_data_b, 10);
        wr(0, 7);
        rd_addr_a = 0; rd_addr_b = 0; #1;
        chk("r0_zero_a", rd_data_a, 0);
        chk("r0_zero_b", rd_data_b, 0);
        rd_addr_a = 1; wr_en = 1; wr_addr = 1; wr_data = 99; #1;
        chk("no_bypass", rd_data_a, 15);
        step(); wr_en = 0;
        chk("after_write", rd_data_a, 99);
        // full dump with ready held high
        for (int n = 0; n < 16; n++) wr(4'(n), 32'(n + 100));
        for (int n = 0; n < 16; n++) q.push_back({4'(n), n == 0 ? 32'd0 : 32'(n + 100)});
        done_cnt = 0; dump_ready = 1; dump_start = 1;
        step(); dump_start = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && dump_busy; i++) begin busy_cnt++; step(); end
        chk("busy_cycles", 32'(busy_cnt), 17);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("queue_empty", 32'(q.size()), 0);
        chk("idle_addr", 32'(dump_addr), 0);
        // backpressure, concurrent writes, ignored start, abort
        for (int n = 0; n < 16; n++)
            q.push_back({4'(n), n == 0 ? 32'd0 : n == 9 ? 32'h66 : 32'(n + 100)});
        done_cnt = 0; dump_start = 1;
        step(); dump_start = 0;
        wait_addr(4);
        dump_ready = 0;
        wr(4, 32'h55);
        wr(9, 32'h66);
        step();
        chk("hold_addr", 32'(dump_addr), 4);
        chk("hold_data", dump_data, 104);
        chk("hold_valid", 32'(dump_valid), 1);
        dump_ready = 1;
        wait_addr(6);
        dump_start = 1; step(); dump_start = 0;
        wait_addr(10);
        dump_ready = 0; clr = 0;
        step(); clr = 1;
        chk("abort_busy", 32'(dump_busy), 0);
        chk("abort_valid", 32'(dump_valid), 0);
        chk("abort_done", 32'(dump_done), 0);
        chk("abort_left", 32'(q.size()), 6);
        q.delete();
        step(); step();
        chk("abort_no_done", 32'(done_cnt), 0);
        // restart after abort: bank was cleared
        for (int n = 0; n < 16; n++) q.push_back({4'(n), 32'd0});
        dump_ready = 1; dump_start = 1;
        step(); dump_start = 0;
        for (int i = 0; i < 40 && dump_busy; i++) step();
        chk("restart_done", 32'(done_cnt), 1);
        chk("restart_empty", 32'(q.size()), 0);
        // small bank with ordinary register 0
        s_wr(0, 8'hFF);
        s_rd_a = 0; #1;
        chk("s_r0_write", 32'(s_data_a), 32'hFF);
        for (int n = 1; n < 4; n++) s_wr(2'(n), 8'(n * 17));
        s_rd_b = 3; #1;
        chk("s_r3", 32'(s_data_b), 51);
        sq.push_back({2'd0, 8'hFF});
        for (int n = 1; n < 4; n++) sq.push_back({2'(n), 8'(n * 17)});
        s_ready = 1; s_start = 1;
        step(); s_start = 0;
        for (int i = 0; i < 20 && s_busy; i++) step();
        chk("s_done", 32'(s_done_cnt), 1);
        chk("s_empty", 32'(sq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
